// File: rtl/timer_pkg.sv
// Shared definitions for the timer arbiter: timer register map,
// CTRL bit layout and the arbiter FSM state type.
package timer_pkg;

    // Timer register offsets
    localparam logic [31:0] TMR_CTRL   = 32'h0000_0000;
    localparam logic [31:0] TMR_LOAD   = 32'h0000_0004;
    localparam logic [31:0] TMR_VALUE  = 32'h0000_0008;
    localparam logic [31:0] TMR_STATUS = 32'h0000_000C;

    // CTRL bit positions and the words the arbiter writes
    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_MODE_BIT = 1;
    localparam logic [31:0] CTRL_EN_MASK   = 32'(1) << CTRL_EN_BIT;
    localparam logic [31:0] CTRL_MODE_MASK = 32'(1) << CTRL_MODE_BIT;
    localparam logic [31:0] CTRL_ONESHOT   = CTRL_EN_MASK;   // en=1, mode=0
    localparam logic [31:0] CTRL_OFF       = '0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARB     = 3'd1,
        ST_WR_LOAD = 3'd2,
        ST_WR_CTRL = 3'd3,
        ST_BLANK   = 3'd4,
        ST_WAIT    = 3'd5,
        ST_STOP    = 3'd6,
        ST_DONE    = 3'd7
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping N_REQ-1 -> 0. The pointer register lives in the caller.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] winner_oh,
    output logic [IDX_W-1:0] winner_idx,
    output logic             valid
);

    // Scan from ptr upward and take the first asserted request
    always_comb begin
        logic [IDX_W-1:0] j;
        winner_oh  = '0;
        winner_idx = '0;
        valid      = 1'b0;
        j          = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            j = IDX_W'((32'(ptr) + k) % N_REQ);
            if (!valid && req[j]) begin
                valid        = 1'b1;
                winner_oh[j] = 1'b1;
                winner_idx   = j;
            end
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin sharing of one timer_ip among N_REQ one-shot delay clients.
// Optional feature macro: TMR_ARB_ABORT_EN (granted requester may cut its
// wait short via req_abort; the transfer still stops the timer and pulses done).
module timer_arbiter
    import timer_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int LOAD_W = 32
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*LOAD_W-1:0]   req_load,
    input  logic [N_REQ-1:0]          req_abort,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REQ-1:0]          done,
    output logic                      busy,
    output logic                      tmr_sel,
    output logic                      tmr_we,
    output logic [31:0]               tmr_addr,
    output logic [31:0]               tmr_wdata,
    input  logic                      tmr_timeout
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic [LOAD_W-1:0] load_q, load_d;
    logic [N_REQ-1:0]  grant_d, done_d;
    logic              busy_d, sel_d;
    logic [31:0]       addr_d, wdata_d;

    logic [N_REQ-1:0]  arb_oh;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_valid;
    logic              abort_hit;

    rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
        .req        (req),
        .ptr        (ptr_q),
        .winner_oh  (arb_oh),
        .winner_idx (arb_idx),
        .valid      (arb_valid)
    );

`ifdef TMR_ARB_ABORT_EN
    // Only the granted requester's abort line matters
    always_comb abort_hit = req_abort[win_q];
`else
    logic unused_abort;
    // Abort feature compiled out: line is observed nowhere
    always_comb begin
        abort_hit    = 1'b0;
        unused_abort = ^req_abort;
    end
`endif

    // Next-state logic. The winner and pointer are taken on the IDLE->ARB
    // edge so that grant, being registered, is already valid during ARB;
    // the load slice is latched on leaving ARB.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        load_d  = load_q;
        grant_d = grant;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d = ST_ARB;
                    win_d   = arb_idx;
                    grant_d = arb_oh;
                    ptr_d   = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
                end
            end
            ST_ARB: begin
                load_d  = req_load[32'(win_q) * LOAD_W +: LOAD_W];
                state_d = (load_d == '0) ? ST_DONE : ST_WR_LOAD;
            end
            ST_WR_LOAD: state_d = abort_hit ? ST_STOP : ST_WR_CTRL;
            ST_WR_CTRL: state_d = abort_hit ? ST_STOP : ST_BLANK;
            ST_BLANK:   state_d = abort_hit ? ST_STOP : ST_WAIT;
            ST_WAIT: begin
                if (tmr_timeout || abort_hit) state_d = ST_STOP;
            end
            ST_STOP: state_d = ST_DONE;
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output values for the coming state, registered below
    always_comb begin
        busy_d  = (state_d != ST_IDLE);
        sel_d   = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        done_d  = '0;
        case (state_d)
            ST_WR_LOAD: begin
                sel_d   = 1'b1;
                addr_d  = TMR_LOAD;
                wdata_d = 32'(load_d);
            end
            ST_WR_CTRL: begin
                sel_d   = 1'b1;
                addr_d  = TMR_CTRL;
                wdata_d = CTRL_ONESHOT;
            end
            ST_STOP: begin
                sel_d   = 1'b1;
                addr_d  = TMR_CTRL;
                wdata_d = CTRL_OFF;
            end
            ST_DONE: done_d = grant_d;
            default: ;
        endcase
    end

    // State, bookkeeping and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            load_q    <= '0;
            grant     <= '0;
            done      <= '0;
            busy      <= 1'b0;
            tmr_sel   <= 1'b0;
            tmr_we    <= 1'b0;
            tmr_addr  <= '0;
            tmr_wdata <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            load_q    <= load_d;
            grant     <= grant_d;
            done      <= done_d;
            busy      <= busy_d;
            tmr_sel   <= sel_d;
            tmr_we    <= sel_d;
            tmr_addr  <= addr_d;
            tmr_wdata <= wdata_d;
        end
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Self-checking bench for timer_arbiter with a behavioural one-shot timer.
// Expected behaviour comes from a transfer-timeline model: each transfer is
// described by its arbitration cycle, latched load, stop cycle and done cycle.
module tb_timer_arbiter;
    localparam int N  = 4;
    localparam int LW = 32;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  req_abort = '0;
    logic [N*LW-1:0] req_load = '0;
    logic [N-1:0]  grant, done;
    logic          busy, tmr_sel, tmr_we, tmr_timeout;
    logic [31:0]   tmr_addr, tmr_wdata;

    always #5 clk = ~clk;

    timer_arbiter #(.N_REQ(N), .LOAD_W(LW)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req         (req),
        .req_load    (req_load),
        .req_abort   (req_abort),
        .grant       (grant),
        .done        (done),
        .busy        (busy),
        .tmr_sel     (tmr_sel),
        .tmr_we      (tmr_we),
        .tmr_addr    (tmr_addr),
        .tmr_wdata   (tmr_wdata),
        .tmr_timeout (tmr_timeout)
    );

    // Timer stand-in: LOAD@4 stores the count, CTRL@0 sets enable, reloads
    // and clears timeout; timeout rises LOAD ticks after the CTRL write.
    logic [31:0] t_load, t_cnt;
    logic        t_en, t_to;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            t_load <= '0; t_cnt <= '0; t_en <= 1'b0; t_to <= 1'b0;
        end else if (tmr_sel && tmr_we) begin
            if (tmr_addr == 32'h4) t_load <= tmr_wdata;
            else if (tmr_addr == 32'h0) begin
                t_en <= tmr_wdata[0]; t_to <= 1'b0; t_cnt <= t_load;
            end
        end else if (t_en && !t_to) begin
            if (t_cnt <= 32'd1) begin t_to <= 1'b1; t_en <= 1'b0; end
            else t_cnt <= t_cnt - 32'd1;
        end
    end
    assign tmr_timeout = t_to;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // inputs as sampled at the latest posedge
    logic [N-1:0]    e_req, e_abort;
    logic [N*LW-1:0] e_load;
    logic            tmo_prev;

    // reference model state
    int          m_ptr, m_win, m_s, m_stop, m_done;
    bit          m_active, m_idle_prev, m_L_valid;
    logic [31:0] m_L;
    int          ndone, last_done_idx, last_done_cyc, last_start_cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_active = 0; m_idle_prev = 1; m_L_valid = 0;
        m_stop = -1; m_done = -1; tmo_prev = 1'b0;
    endtask

    task automatic observe();
        logic [N-1:0] eg, ed;
        logic         ew;
        logic [31:0]  ea, edat;
        int c;
        c = cyc;
        eg = '0; ed = '0; ew = 1'b0; ea = '0; edat = '0;
        if (!m_active && m_idle_prev && e_req != '0) begin
            m_win = rr_pick(e_req, m_ptr);
            m_ptr = (m_win + 1) % N;
            m_active = 1; m_s = c; m_L_valid = 0; m_stop = -1; m_done = -1;
            last_start_cyc = c;
        end
        if (m_active) begin
            if (c == m_s + 1) begin
                m_L = e_load[m_win*LW +: LW];
                m_L_valid = 1;
                if (m_L == 0) m_done = c;
            end
            if (m_L_valid && m_L != 0 && m_stop < 0 && c - 1 >= m_s + 1) begin
                if (c - 1 >= m_s + 4 && tmo_prev) begin m_stop = c; m_done = c + 1; end
`ifdef TMR_ARB_ABORT_EN
                if (e_abort[m_win]) begin m_stop = c; m_done = c + 1; end
`endif
            end
            eg[m_win] = 1'b1;
            if (c == m_done) ed = eg;
            if (m_L_valid && m_L != 0) begin
                if (c == m_s + 1) begin ew = 1'b1; ea = 32'h4; edat = m_L; end
                else if (c == m_stop) begin ew = 1'b1; ea = 32'h0; edat = 32'h0; end
                else if (c == m_s + 2) begin ew = 1'b1; ea = 32'h0; edat = 32'h1; end
            end
        end
        chk("grant", 64'(grant), 64'(eg));
        chk("done", 64'(done), 64'(ed));
        chk("busy", 64'(busy), 64'(m_active));
        chk("tmr_sel", 64'(tmr_sel), 64'(ew));
        chk("tmr_we", 64'(tmr_we), 64'(ew));
        if (ew) begin
            chk("tmr_addr", 64'(tmr_addr), 64'(ea));
            chk("tmr_wdata", 64'(tmr_wdata), 64'(edat));
        end
        tmo_prev = tmr_timeout;
        if (m_active && c == m_done) begin
            m_active = 0; m_idle_prev = 0;
            last_done_idx = m_win; last_done_cyc = c; ndone++;
        end else begin
            m_idle_prev = !m_active;
        end
    endtask

    task automatic step();
        @(posedge clk);
        e_req = req; e_abort = req_abort; e_load = req_load;
        @(negedge clk);
        cyc++;
        observe();
    endtask

    task automatic wait_done(input int budget, output int idx, output int at);
        int n0;
        bit got;
        n0 = ndone; idx = -1; at = -1; got = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (ndone != n0) begin
                idx = last_done_idx; at = last_done_cyc; got = 1;
                break;
            end
        end
        chk("done_within_budget", 64'(got), 64'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, 64'(grant), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_sel"}, 64'({tmr_sel, tmr_we}), 64'd0);
        chk({tag, "_bus"}, {tmr_addr, tmr_wdata}, 64'd0);
    endtask

    // Asynchronous reset asserted mid-cycle, released on a falling edge
    task automatic reset_mid();
        #2 resetn = 1'b0;
        #1 chk_all_zero("async_reset");
        repeat (2) @(negedge clk);
        chk_all_zero("held_reset");
        resetn = 1'b1;
        model_reset();
    endtask

    initial begin
        int idx, at, t0, ab, n0;
        bit seen;
        model_reset();
        ndone = 0; last_done_idx = -1; last_done_cyc = -1; last_start_cyc = -1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        resetn = 1'b1;

        // simultaneous requests served in rr order from pointer 0
        req_load = {32'd6, 32'd5, 32'd4, 32'd3};
        req = 4'b1111;
        for (int k = 0; k < N; k++) begin
            wait_done(60, idx, at);
            chk("all_req_order", 64'(idx), 64'(k));
            if (idx >= 0) req[idx] = 1'b0;
        end
        req = '0;
        repeat (2) step();

        // single request, load 10: done = req + load + 6 with this timer
        req_load[0 +: LW] = 32'd10;
        req[0] = 1'b1; t0 = cyc;
        wait_done(60, idx, at);
        chk("single_idx", 64'(idx), 64'd0);
        chk("single_latency", 64'(at - t0), 64'd16);
        req[0] = 1'b0;
        repeat (2) step();

        // zero load: ARB straight to DONE, timer bus untouched
        req_load[1*LW +: LW] = 32'd0;
        req[1] = 1'b1; t0 = cyc;
        wait_done(20, idx, at);
        chk("zero_load_idx", 64'(idx), 64'd1);
        chk("zero_load_latency", 64'(at - t0), 64'd2);
        req[1] = 1'b0;
        repeat (2) step();

        // req[2] held after its done while req[3] waits: 2, 3, then 2 again
        req_load[2*LW +: LW] = 32'd2;
        req_load[3*LW +: LW] = 32'd3;
        req[3:2] = 2'b11;
        wait_done(40, idx, at);
        chk("rr_first", 64'(idx), 64'd2);
        wait_done(40, idx, at);
        chk("rr_fair_next", 64'(idx), 64'd3);
        req[3] = 1'b0;
        wait_done(40, idx, at);
        chk("rr_back", 64'(idx), 64'd2);
        req = '0;
        repeat (2) step();

        // reset while waiting on the timer, then a fresh request
        req_load[0 +: LW] = 32'd50;
        req[0] = 1'b1;
        repeat (12) step();
        req = '0;
        reset_mid();
        req_load[1*LW +: LW] = 32'd5;
        req[1] = 1'b1;
        wait_done(40, idx, at);
        chk("after_reset_idx", 64'(idx), 64'd1);
        req[1] = 1'b0;
        repeat (2) step();

`ifdef TMR_ARB_ABORT_EN
        // abort in the 5th WAIT cycle: STOP next cycle, done two cycles on
        req_load[0 +: LW] = 32'd100;
        req[0] = 1'b1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin step(); seen = (grant != '0); end
        chk("abort_started", 64'(seen), 64'd1);
        for (int i = 0; i < 20 && cyc < last_start_cyc + 8; i++) step();
        req_abort[0] = 1'b1; ab = cyc;
        step();
        req_abort = '0;
        wait_done(20, idx, at);
        chk("abort_done_latency", 64'(at - ab), 64'd2);
        req[0] = 1'b0;
        repeat (2) step();
`endif

        // randomized traffic: holds, early drops, re-requests, load churn, stray aborts
        n0 = ndone;
        for (int i = 0; i < 3000; i++) begin
            step();
            for (int r = 0; r < N; r++) begin
                if (req[r] && done[r]) req[r] = ($urandom % 4 == 0);
                else if (!req[r] && $urandom % 8 == 0) begin
                    req[r] = 1'b1;
                    req_load[r*LW +: LW] = $urandom % 9;
                end else if (req[r] && $urandom % 64 == 0) req[r] = 1'b0;
                if ($urandom % 16 == 0) req_load[r*LW +: LW] = $urandom % 9;
                req_abort[r] = ($urandom % 16 == 0);
            end
        end
        chk("random_progress", 64'(ndone > n0 + 50), 64'd1);
        req = '0; req_abort = '0;
        for (int i = 0; i < 30 && (busy || m_active); i++) step();
        chk("final_idle", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
